// File: rtl/mult_pkg.sv
// Shared types and widths for the multiple-detector sweep sequencer.
package mult_pkg;

  localparam int unsigned OP_W  = 4;
  localparam int unsigned CNT_W = 5;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SWEEP  = 2'd1,
    FINISH = 2'd2
  } state_t;

endpackage

// File: rtl/mult_dwell_timer.sv
// Dwell counter: clears on request, counts while enabled, flags DWELL-1.
module mult_dwell_timer #(
  parameter int unsigned DWELL = 4,
  parameter int unsigned DW_W  = 24
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_tc
);

  localparam logic [DW_W-1:0] TC_VAL = DW_W'(DWELL - 1);

  logic [DW_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= r_cnt + DW_W'(1);
    end
  end

  assign o_tc = (r_cnt == TC_VAL);

endmodule

// File: rtl/mult_sweep_ctrl.sv
// Sweeps the detector operand lo..hi (mod 16), holding each for DWELL cycles,
// and counts how many operands raised each detector flag.
module mult_sweep_ctrl
  import mult_pkg::*;
#(
  parameter int unsigned DWELL = 4,
  parameter int unsigned DW_W  = 24
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [OP_W-1:0]  lo,
  input  logic [OP_W-1:0]  hi,
  input  logic             m3_flag,
  input  logic             m2_flag,
  output logic [OP_W-1:0]  op_a,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] cnt3,
  output logic [CNT_W-1:0] cnt2
);

  state_t r_state, w_next;

  logic [OP_W-1:0]  r_op;
  logic [OP_W-1:0]  r_hi;
  logic [CNT_W-1:0] r_cnt3;
  logic [CNT_W-1:0] r_cnt2;

  logic w_accept;
  logic w_sweep;
  logic w_tc;
  logic w_sample;
  logic w_last;

  assign w_accept = (r_state == IDLE) && start;
  assign w_sweep  = (r_state == SWEEP);
  assign w_sample = w_sweep && w_tc;
  assign w_last   = w_sample && (r_op == r_hi);

  // Counter clear on the last sample is harmless: it is reloaded on the next start.
  mult_dwell_timer #(
    .DWELL (DWELL),
    .DW_W  (DW_W)
  ) u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .i_clr (w_accept || w_sample),
    .i_en  (w_sweep),
    .o_tc  (w_tc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (start)  w_next = SWEEP;
      SWEEP:   if (w_last) w_next = FINISH;
      FINISH:  w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op   <= '0;
      r_hi   <= '0;
      r_cnt3 <= '0;
      r_cnt2 <= '0;
    end else if (w_accept) begin
      r_op   <= lo;
      r_hi   <= hi;
      r_cnt3 <= '0;
      r_cnt2 <= '0;
    end else if (w_sample) begin
      r_cnt3 <= r_cnt3 + CNT_W'(m3_flag);
      r_cnt2 <= r_cnt2 + CNT_W'(m2_flag);
      if (!w_last) begin
        r_op <= r_op + OP_W'(1);
      end
    end
  end

  assign op_a = r_op;
  assign busy = w_sweep;
  assign done = (r_state == FINISH);
  assign cnt3 = r_cnt3;
  assign cnt2 = r_cnt2;

endmodule

// File: tb/tb_mult_sweep_ctrl.sv
// Directed bench for mult_sweep_ctrl: DWELL=4 and DWELL=1 builds with a behavioural detector.
module tb_mult_sweep_ctrl;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       sel   = 1'b0;
  logic [3:0] lo    = '0;
  logic [3:0] hi    = '0;

  logic [3:0] op_4, op_1;
  logic       busy_4, busy_1, done_4, done_1;
  logic [4:0] c3_4, c2_4, c3_1, c2_1;
  logic       m3_4, m2_4, m3_1, m2_1;

  logic [3:0] s_op;
  logic       s_busy, s_done;
  logic [4:0] s_c3, s_c2;

  int n_cmp = 0;
  int n_err = 0;

  int bc, se, ds, gp, nd;

  always #5 clk = ~clk;

  function automatic logic is_m3(input logic [3:0] v);
    return (v != 4'd0) && ((int'(v) % 3) == 0);
  endfunction

  function automatic logic is_m2(input logic [3:0] v);
    return (v != 4'd0) && ((int'(v) % 2) == 0);
  endfunction

  assign m3_4 = is_m3(op_4);
  assign m2_4 = is_m2(op_4);
  assign m3_1 = is_m3(op_1);
  assign m2_1 = is_m2(op_1);

  assign s_op   = sel ? op_1   : op_4;
  assign s_busy = sel ? busy_1 : busy_4;
  assign s_done = sel ? done_1 : done_4;
  assign s_c3   = sel ? c3_1   : c3_4;
  assign s_c2   = sel ? c2_1   : c2_4;

  mult_sweep_ctrl #(.DWELL(4), .DW_W(24)) dut (
    .clk(clk), .rst_n(rst_n), .start(start & ~sel), .lo(lo), .hi(hi),
    .m3_flag(m3_4), .m2_flag(m2_4), .op_a(op_4), .busy(busy_4),
    .done(done_4), .cnt3(c3_4), .cnt2(c2_4)
  );

  mult_sweep_ctrl #(.DWELL(1), .DW_W(24)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start & sel), .lo(lo), .hi(hi),
    .m3_flag(m3_1), .m2_flag(m2_1), .op_a(op_1), .busy(busy_1),
    .done(done_1), .cnt3(c3_1), .cnt2(c2_1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Accepts a sweep, then watches it until done; optionally pulses start mid-sweep.
  task automatic run_sweep(input logic [3:0] l, input logic [3:0] h, input int dw,
                           input int restart_at, output int busy_cyc, output int seq_err,
                           output int done_seen, output int gap);
    int last_busy;
    logic [3:0] e;
    @(negedge clk);
    check("done_idle", s_done, 0);
    lo = l; hi = h; start = 1'b1;
    @(negedge clk);
    start = 1'b0; lo = ~l; hi = ~h;
    busy_cyc = 0; seq_err = 0; done_seen = 0; gap = -1; last_busy = -1;
    for (int t = 0; t < 400; t++) begin
      if (s_busy === 1'b1) begin
        e = 4'(int'(l) + busy_cyc / dw);
        if (s_op !== e) seq_err++;
        busy_cyc++;
        last_busy = t;
      end
      if (s_done === 1'b1) begin
        done_seen = 1;
        gap = t - last_busy;
        break;
      end
      if (t == restart_at) begin
        start = 1'b1; lo = 4'd5; hi = 4'd9;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0;
    check("timeout", done_seen, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got stuck expected finish");
    $fatal(1, "global timeout");
  end

  initial begin
    repeat (3) @(negedge clk);
    check("rst_op",   op_4,   0);
    check("rst_busy", busy_4, 0);
    check("rst_done", done_4, 0);
    check("rst_cnt3", c3_4,   0);
    check("rst_cnt2", c2_4,   0);
    rst_n = 1'b1;

    // full sweep 0..15, DWELL=4
    run_sweep(4'd0, 4'd15, 4, -1, bc, se, ds, gp);
    check("full_busy", bc, 64);
    check("full_seq",  se, 0);
    check("full_gap",  gp, 1);
    check("full_cnt3", s_c3, 5);
    check("full_cnt2", s_c2, 7);

    // single operand 6
    run_sweep(4'd6, 4'd6, 4, -1, bc, se, ds, gp);
    check("one_busy", bc, 4);
    check("one_cnt3", s_c3, 1);
    check("one_cnt2", s_c2, 1);
    check("one_op",   s_op, 6);
    @(negedge clk);
    check("one_hold_op", s_op, 6);
    check("one_hold_c3", s_c3, 1);

    // wrap 14..1
    run_sweep(4'd14, 4'd1, 4, -1, bc, se, ds, gp);
    check("wrap_busy", bc, 16);
    check("wrap_seq",  se, 0);
    check("wrap_cnt3", s_c3, 1);
    check("wrap_cnt2", s_c2, 1);
    check("wrap_op",   s_op, 1);

    // start re-pulsed 10 cycles in with other bounds: ignored
    run_sweep(4'd0, 4'd15, 4, 10, bc, se, ds, gp);
    check("rest_busy", bc, 64);
    check("rest_seq",  se, 0);
    check("rest_gap",  gp, 1);
    check("rest_cnt3", s_c3, 5);
    check("rest_cnt2", s_c2, 7);

    // async reset 20 cycles into a sweep
    @(negedge clk);
    lo = 4'd0; hi = 4'd15; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (19) @(negedge clk);
    check("pre_op",   op_4, 4);
    check("pre_cnt3", c3_4, 1);
    check("pre_cnt2", c2_4, 1);
    #2 rst_n = 1'b0;
    #1;
    check("ar_op",   op_4,   0);
    check("ar_busy", busy_4, 0);
    check("ar_done", done_4, 0);
    check("ar_cnt3", c3_4,   0);
    check("ar_cnt2", c2_4,   0);
    @(negedge clk);
    rst_n = 1'b1;
    nd = 0;
    repeat (6) begin
      @(negedge clk);
      if (done_4 !== 1'b0 || busy_4 !== 1'b0) nd++;
    end
    check("ar_quiet", nd, 0);

    run_sweep(4'd3, 4'd3, 4, -1, bc, se, ds, gp);
    check("post_busy", bc, 4);
    check("post_cnt3", s_c3, 1);
    check("post_cnt2", s_c2, 0);

    // DWELL=1 build, then back-to-back start in the cycle after done
    sel = 1'b1;
    run_sweep(4'd0, 4'd15, 1, -1, bc, se, ds, gp);
    check("d1_busy", bc, 16);
    check("d1_seq",  se, 0);
    check("d1_gap",  gp, 1);
    check("d1_cnt3", s_c3, 5);
    check("d1_cnt2", s_c2, 7);

    run_sweep(4'd2, 4'd4, 1, -1, bc, se, ds, gp);
    check("b2b_busy", bc, 3);
    check("b2b_seq",  se, 0);
    check("b2b_cnt3", s_c3, 1);
    check("b2b_cnt2", s_c2, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
